// File: rtl/fpu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_ctrl_if
// Brief    : Handshake, status and strobe bundle between FPU wrapper/datapath
//            and the add/multiply sequencer.
// Revision : 1.0
// ============================================================================
interface fpu_seq_ctrl_if #(
   parameter int EXP_W = 8
);
   logic             start;
   logic             op;
   logic             exp_a_bigger;
   logic [EXP_W-1:0] exp_diff;
   logic [1:0]       res_msb;
   logic             res_zero;
   logic             round_ovf;

   logic             load_ops;
   logic             sel_big;
   logic             sel_small;
   logic             align_shift;
   logic             alu_go;
   logic             alu_op;
   logic             norm_shr;
   logic             norm_shl;
   logic             round_en;
   logic             sel_round;
   logic             busy;
   logic             done;

   // Wrapper/datapath side
   modport master (
      output start, op, exp_a_bigger, exp_diff, res_msb, res_zero, round_ovf,
      input  load_ops, sel_big, sel_small, align_shift, alu_go, alu_op,
             norm_shr, norm_shl, round_en, sel_round, busy, done
   );

   // Sequencer side
   modport slave (
      input  start, op, exp_a_bigger, exp_diff, res_msb, res_zero, round_ovf,
      output load_ops, sel_big, sel_small, align_shift, alu_go, alu_op,
             norm_shr, norm_shl, round_en, sel_round, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/fpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_ctrl
// Brief    : Multi-cycle sequencer for the single-precision add/multiply
//            datapath; owns the alignment and normalize shift counters.
// Revision : 1.0
// ============================================================================
module fpu_seq_ctrl #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 27
) (
   input  wire           clk,
   input  wire           rst_n,
   fpu_seq_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(FRAC_W + 1);
   localparam int CMP_W = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;
   localparam logic [CNT_W-1:0] C_ALIGN_MAX = CNT_W'(FRAC_W);
   localparam logic [CNT_W-1:0] C_NORM_MAX  = CNT_W'(FRAC_W - 1);
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD   = 4'd1,
      S_ALIGN  = 4'd2,
      S_EXEC   = 4'd3,
      S_NORM   = 4'd4,
      S_ROUND  = 4'd5,
      S_CHECK  = 4'd6,
      S_RENORM = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_op;
   logic             r_a_big;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_k;

   logic [CMP_W-1:0] w_diff_ext;
   logic [CNT_W-1:0] w_diff_clamp;

   logic w_load_ops;
   logic w_align_shift;
   logic w_alu_go;
   logic w_norm_shr;
   logic w_norm_shl;
   logic w_round_en;
   logic w_sel_round;
   logic w_done;
   logic w_busy;
   logic w_active;

   // Large differences shift everything into sticky; cap at the fraction width.
   assign w_diff_ext   = CMP_W'(bus.exp_diff);
   assign w_diff_clamp = (w_diff_ext > CMP_W'(FRAC_W)) ? C_ALIGN_MAX
                                                       : CNT_W'(w_diff_ext);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 1'b0;
         r_a_big <= 1'b0;
         r_cnt   <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op    <= bus.op;
                  r_a_big <= bus.exp_a_bigger;
                  r_cnt   <= w_diff_clamp;
               end
            end
            S_ALIGN: r_cnt <= r_cnt - C_ONE;
            S_EXEC:  r_k   <= '0;
            S_NORM: begin
               if (w_norm_shl) begin
                  r_k <= r_k + C_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next        = r_state;
      w_load_ops    = 1'b0;
      w_align_shift = 1'b0;
      w_alu_go      = 1'b0;
      w_norm_shr    = 1'b0;
      w_norm_shl    = 1'b0;
      w_round_en    = 1'b0;
      w_sel_round   = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_load_ops = 1'b1;
            // Multiply needs no alignment; neither does an exponent tie.
            if (r_op || (r_cnt == '0)) begin
               w_next = S_EXEC;
            end else begin
               w_next = S_ALIGN;
            end
         end
         S_ALIGN: begin
            w_align_shift = 1'b1;
            if (r_cnt <= C_ONE) begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_go = 1'b1;
            w_next   = S_NORM;
         end
         S_NORM: begin
            if (bus.res_zero) begin
               w_next = S_ROUND;
            end else if (bus.res_msb[1]) begin
               w_norm_shr = 1'b1;
               w_next     = S_ROUND;
            end else if (!bus.res_msb[0] && (r_k < C_NORM_MAX)) begin
               w_norm_shl = 1'b1;
            end else begin
               w_next = S_ROUND;
            end
         end
         S_ROUND: begin
            w_round_en = 1'b1;
            w_next     = S_CHECK;
         end
         S_CHECK: begin
            w_next = bus.round_ovf ? S_RENORM : S_DONE;
         end
         S_RENORM: begin
            w_norm_shr  = 1'b1;
            w_sel_round = 1'b1;
            w_next      = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (!bus.start) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_active = (r_state != S_IDLE);
   assign w_busy   = w_active && (r_state != S_DONE);

   assign bus.load_ops    = w_load_ops;
   assign bus.sel_big     = w_active & ~r_a_big;
   assign bus.sel_small   = w_active &  r_a_big;
   assign bus.align_shift = w_align_shift;
   assign bus.alu_go      = w_alu_go;
   assign bus.alu_op      = w_active & r_op;
   assign bus.norm_shr    = w_norm_shr;
   assign bus.norm_shl    = w_norm_shl;
   assign bus.round_en    = w_round_en;
   assign bus.sel_round   = w_sel_round;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_seq_ctrl
// Brief    : Scoreboard bench for fpu_seq_ctrl with a reactive datapath model.
// Revision : 1.0
// ============================================================================
module tb_fpu_seq_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_seq_ctrl_if #(.EXP_W(8)) bus ();

   fpu_seq_ctrl #(.EXP_W(8), .FRAC_W(27)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // lat, align, shl, shr, sel_round, alu_go, round_en, sel_big, sel_small, alu_op
   typedef struct {
      int lat; int al; int shl; int shr; int sr;
      int alu; int rnd; int sbig; int ssml; int aop;
   } exp_t;
   exp_t q[$];

   int         want_shl  = 0;
   logic [1:0] want_msb  = 2'b01;
   logic       want_zero = 1'b0;
   logic       want_ovf  = 1'b0;
   int         dp_shl    = 0;

   // Datapath model: result stays un-normalized until enough left shifts seen.
   assign bus.res_msb   = (dp_shl < want_shl) ? 2'b00 : want_msb;
   assign bus.res_zero  = want_zero;
   assign bus.round_ovf = want_ovf;

   always @(posedge clk) begin
      if (bus.load_ops)      dp_shl <= 0;
      else if (bus.norm_shl) dp_shl <= dp_shl + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] all_outs();
      return {bus.load_ops, bus.sel_big, bus.sel_small, bus.align_shift,
              bus.alu_go, bus.alu_op, bus.norm_shr, bus.norm_shl,
              bus.round_en, bus.sel_round, bus.busy, bus.done};
   endfunction

   // Monitor: accumulate strobe counts per operation, score on done rising.
   initial begin
      int cyc, n_al, n_shl, n_shr, n_sr, n_alu, n_rnd;
      bit trk, prev_done;
      exp_t e;
      cyc = 0; n_al = 0; n_shl = 0; n_shr = 0; n_sr = 0; n_alu = 0; n_rnd = 0;
      trk = 0; prev_done = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            trk = 0;
            prev_done = 0;
         end else begin
            if (bus.load_ops) begin
               trk = 1; cyc = 0;
               n_al = 0; n_shl = 0; n_shr = 0; n_sr = 0; n_alu = 0; n_rnd = 0;
            end else if (trk) begin
               cyc++;
            end
            if (trk) begin
               n_al  += int'(bus.align_shift);
               n_shl += int'(bus.norm_shl);
               n_shr += int'(bus.norm_shr);
               n_sr  += int'(bus.sel_round);
               n_alu += int'(bus.alu_go);
               n_rnd += int'(bus.round_en);
            end
            if (bus.done && !prev_done) begin
               if (q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("latency",     cyc,   e.lat);
                  chk("align_cnt",   n_al,  e.al);
                  chk("shl_cnt",     n_shl, e.shl);
                  chk("shr_cnt",     n_shr, e.shr);
                  chk("sel_round",   n_sr,  e.sr);
                  chk("alu_go_cnt",  n_alu, e.alu);
                  chk("round_en",    n_rnd, e.rnd);
                  chk("sel_big",     int'(bus.sel_big),   e.sbig);
                  chk("sel_small",   int'(bus.sel_small), e.ssml);
                  chk("alu_op",      int'(bus.alu_op),    e.aop);
               end
               trk = 0;
            end
            prev_done = bus.done;
         end
      end
   end

   task automatic run_op(input bit op, input bit abig, input int diff,
                         input int wshl, input logic [1:0] wmsb, input bit wz,
                         input bit wovf, input bit drop, input exp_t e);
      bit got;
      @(negedge clk);
      want_shl = wshl; want_msb = wmsb; want_zero = wz; want_ovf = wovf;
      bus.op = op; bus.exp_a_bigger = abig; bus.exp_diff = 8'(diff);
      bus.start = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (drop) bus.start = 1'b0;
      bus.op = ~op; bus.exp_a_bigger = ~abig; bus.exp_diff = 8'hA5;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.done) got = 1;
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
      end else if (drop) begin
         @(negedge clk);
         chk("done_one_cycle", int'(bus.done), 0);
         chk("idle_busy",      int'(bus.busy), 0);
      end else begin
         repeat (2) @(negedge clk);
         chk("done_hold", int'(bus.done), 1);
         chk("done_busy", int'(bus.busy), 0);
         bus.start = 1'b0;
         @(negedge clk);
         chk("done_release", int'(bus.done), 0);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 1'b0; bus.exp_a_bigger = 1'b0; bus.exp_diff = '0;
      repeat (2) @(negedge clk);
      chk("reset_outs", int'(all_outs()), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", int'(all_outs()), 0);

      run_op(1'b0, 1'b1, 3,   0,   2'b01, 1'b0, 1'b0, 1'b0, '{8, 3, 0, 0, 0, 1, 1, 0, 1, 0});
      run_op(1'b1, 1'b1, 5,   0,   2'b10, 1'b0, 1'b1, 1'b1, '{6, 0, 0, 2, 1, 1, 1, 0, 1, 1});
      run_op(1'b0, 1'b0, 200, 0,   2'b01, 1'b0, 1'b0, 1'b0, '{32, 27, 0, 0, 0, 1, 1, 1, 0, 0});
      run_op(1'b0, 1'b1, 0,   4,   2'b01, 1'b0, 1'b0, 1'b1, '{9, 0, 4, 0, 0, 1, 1, 0, 1, 0});
      run_op(1'b0, 1'b1, 0,   0,   2'b00, 1'b1, 1'b0, 1'b1, '{5, 0, 0, 0, 0, 1, 1, 0, 1, 0});
      run_op(1'b0, 1'b1, 0,   100, 2'b00, 1'b0, 1'b0, 1'b1, '{31, 0, 26, 0, 0, 1, 1, 0, 1, 0});
      run_op(1'b0, 1'b0, 1,   0,   2'b01, 1'b0, 1'b1, 1'b0, '{7, 1, 0, 1, 1, 1, 1, 1, 0, 0});
      run_op(1'b0, 1'b1, 27,  0,   2'b01, 1'b0, 1'b0, 1'b1, '{32, 27, 0, 0, 0, 1, 1, 0, 1, 0});

      // Asynchronous reset in the third alignment cycle of an add.
      @(negedge clk);
      want_shl = 0; want_msb = 2'b01; want_zero = 1'b0; want_ovf = 1'b0;
      bus.op = 1'b0; bus.exp_a_bigger = 1'b1; bus.exp_diff = 8'd10; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_align", int'(bus.align_shift), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", int'(all_outs()), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_done", int'(bus.done), 0);
      chk("post_reset_outs", int'(all_outs()), 0);

      repeat (2) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
